// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: branch opcodes, run state and defaults.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_JMP  = 4'd1,
        OP_JZ   = 4'd2,
        OP_JNZ  = 4'd3,
        OP_JC   = 4'd4,
        OP_JNC  = 4'd5,
        OP_JB   = 4'd6,
        OP_JNB  = 4'd7,
        OP_CALL = 4'd8,
        OP_RET  = 4'd9,
        OP_HALT = 4'd15
    } op_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // True when a jump-class opcode redirects to TARGET for the given flags.
    function automatic logic jump_taken(
        input logic [3:0] op,
        input logic       c,
        input logic       z,
        input logic       b
    );
        logic res;
        res = 1'b0;
        case (op)
            OP_JMP:  res = 1'b1;
            OP_JZ:   res = z;
            OP_JNZ:  res = ~z;
            OP_JC:   res = c;
            OP_JNC:  res = ~c;
            OP_JB:   res = b;
            OP_JNB:  res = ~b;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cpu_ret_stack.sv
// Return-address LIFO; the top entry is readable combinationally so a RET
// can redirect the PC in the same cycle it is issued.
module cpu_ret_stack
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0]  SP_FULL = SP_W'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp_reg;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (sp_reg == SP_FULL);
    assign empty   = (sp_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty & ~push;

    // SP counts 0..DEPTH, so its low bits address the next free slot.
    assign wr_idx   = sp_reg[IDX_W-1:0];
    assign rd_idx   = wr_idx - IDX_ONE;
    assign top_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_reg <= '0;
        end else if (push_ok) begin
            sp_reg <= sp_reg + SP_ONE;
        end else if (pop_ok) begin
            sp_reg <= sp_reg - SP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_pc_branch.sv
// Program counter and branch decision: picks the next fetch address from the
// opcode and registered flags, manages CALL/RET and the RUN/HALTED state.
module cpu_pc_branch
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [3:0]        OP,
    input  logic [ADDR_W-1:0] TARGET,
    input  logic              C,
    input  logic              Z,
    input  logic              B,
    output logic [ADDR_W-1:0] PC,
    output logic              TAKEN,
    output logic              HALTED,
    output logic              STK_OVF,
    output logic              STK_UNF
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_e            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic              taken_reg;
    logic              taken_next;
    logic              ovf_reg;
    logic              unf_reg;

    logic              push_req;
    logic              pop_req;
    logic              set_ovf;
    logic              set_unf;
    logic              halt_req;
    logic              advance;

    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;

    assign pc_inc  = pc_reg + PC_ONE;
    assign advance = RST & EN & (state_reg == ST_RUN);

    cpu_ret_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (advance & push_req),
        .pop       (advance & pop_req),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        pc_next    = pc_inc;
        taken_next = 1'b0;
        push_req   = 1'b0;
        pop_req    = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        halt_req   = 1'b0;
        if (jump_taken(OP, C, Z, B)) begin
            pc_next    = TARGET;
            taken_next = 1'b1;
        end else begin
            case (OP)
                OP_CALL: begin
                    if (stk_full) begin
                        set_ovf = 1'b1;
                    end else begin
                        push_req   = 1'b1;
                        pc_next    = TARGET;
                        taken_next = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        pop_req    = 1'b1;
                        pc_next    = stk_top;
                        taken_next = 1'b1;
                    end
                end
                OP_HALT: begin
                    pc_next  = pc_reg;
                    halt_req = 1'b1;
                end
                // Not-taken conditionals, NOP and unassigned codes fall through.
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg <= ST_RUN;
            pc_reg    <= '0;
            taken_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else if (state_reg == ST_HALTED) begin
            taken_reg <= 1'b0;
        end else if (EN) begin
            pc_reg    <= pc_next;
            taken_reg <= taken_next;
            ovf_reg   <= ovf_reg | set_ovf;
            unf_reg   <= unf_reg | set_unf;
            if (halt_req) begin
                state_reg <= ST_HALTED;
            end
        end
    end

    assign PC      = pc_reg;
    assign TAKEN   = taken_reg;
    assign HALTED  = (state_reg == ST_HALTED);
    assign STK_OVF = ovf_reg;
    assign STK_UNF = unf_reg;

endmodule

// File: tb/tb_cpu_pc_branch.sv
// Bench for cpu_pc_branch: directed vector table, hand sequences and random
// stimulus compared against a queue-based reference model.
module tb_cpu_pc_branch;

    localparam logic [3:0] NOP  = 4'd0;
    localparam logic [3:0] JMP  = 4'd1;
    localparam logic [3:0] JZ   = 4'd2;
    localparam logic [3:0] JNZ  = 4'd3;
    localparam logic [3:0] JC   = 4'd4;
    localparam logic [3:0] JNC  = 4'd5;
    localparam logic [3:0] JB   = 4'd6;
    localparam logic [3:0] JNB  = 4'd7;
    localparam logic [3:0] CALL = 4'd8;
    localparam logic [3:0] RET  = 4'd9;
    localparam logic [3:0] HALT = 4'd15;
    localparam int         DEPTH = 4;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [3:0] OP;
    logic [7:0] TARGET;
    logic       C;
    logic       Z;
    logic       B;
    logic [7:0] PC;
    logic       TAKEN;
    logic       HALTED;
    logic       STK_OVF;
    logic       STK_UNF;

    cpu_pc_branch #(
        .ADDR_W      (8),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .OP      (OP),
        .TARGET  (TARGET),
        .C       (C),
        .Z       (Z),
        .B       (B),
        .PC      (PC),
        .TAKEN   (TAKEN),
        .HALTED  (HALTED),
        .STK_OVF (STK_OVF),
        .STK_UNF (STK_UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] op;
        logic [7:0] tgt;
        logic       c;
        logic       z;
        logic       b;
        logic [7:0] pc;
        logic       taken;
        logic       halted;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int   m_pc;
    bit   m_taken;
    bit   m_halted;
    bit   m_ovf;
    bit   m_unf;
    int   m_stack[$];

    function automatic vec_t mk(
        input logic rst, input logic en, input logic [3:0] op, input logic [7:0] tgt,
        input logic c, input logic z, input logic b,
        input logic [7:0] pc, input logic taken, input logic halted,
        input logic ovf, input logic unf
    );
        vec_t v;
        v.rst = rst; v.en = en; v.op = op; v.tgt = tgt;
        v.c = c; v.z = z; v.b = b;
        v.pc = pc; v.taken = taken; v.halted = halted; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic [3:0] op,
                         input logic [7:0] tgt, input logic c, input logic z, input logic b);
        RST = rst; EN = en; OP = op; TARGET = tgt; C = c; Z = z; B = b;
        @(posedge CLK);
        #1;
    endtask

    function automatic void model_update(input logic rst, input logic en, input logic [3:0] op,
                                         input logic [7:0] tgt, input logic c, input logic z,
                                         input logic b);
        int  seq;
        bit  go;
        if (!rst) begin
            m_pc = 0; m_taken = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
            m_stack.delete();
            return;
        end
        if (m_halted) begin
            m_taken = 0;
            return;
        end
        if (!en) return;
        seq = (m_pc + 1) % 256;
        go = (op == JMP) || (op == JZ && z) || (op == JNZ && !z) || (op == JC && c) ||
             (op == JNC && !c) || (op == JB && b) || (op == JNB && !b);
        m_taken = 0;
        if (go) begin
            m_pc = int'(tgt); m_taken = 1;
        end else if (op == CALL) begin
            if (m_stack.size() < DEPTH) begin
                m_stack.push_back(seq);
                m_pc = int'(tgt); m_taken = 1;
            end else begin
                m_pc = seq; m_ovf = 1;
            end
        end else if (op == RET) begin
            if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back(); m_taken = 1;
            end else begin
                m_pc = seq; m_unf = 1;
            end
        end else if (op == HALT) begin
            m_halted = 1;
        end else begin
            m_pc = seq;
        end
    endfunction

    task automatic mstep(input string tag, input logic rst, input logic en, input logic [3:0] op,
                         input logic [7:0] tgt, input logic c, input logic z, input logic b);
        drive(rst, en, op, tgt, c, z, b);
        model_update(rst, en, op, tgt, c, z, b);
        chk({tag, ".pc"},     32'(PC),      32'(m_pc));
        chk({tag, ".taken"},  32'(TAKEN),   32'(m_taken));
        chk({tag, ".halted"}, 32'(HALTED),  32'(m_halted));
        chk({tag, ".ovf"},    32'(STK_OVF), 32'(m_ovf));
        chk({tag, ".unf"},    32'(STK_UNF), 32'(m_unf));
    endtask

    initial begin
        RST = 1'b0; EN = 1'b0; OP = NOP; TARGET = '0; C = 1'b0; Z = 1'b0; B = 1'b0;

        //            rst en op    tgt    c z b    pc    tk h ov un
        tbl.push_back(mk(0, 1, NOP,  8'h00, 0,0,0, 8'h00, 0,0,0,0));
        tbl.push_back(mk(1, 1, NOP,  8'h00, 0,0,0, 8'h01, 0,0,0,0));
        tbl.push_back(mk(1, 1, NOP,  8'h00, 0,0,0, 8'h02, 0,0,0,0));
        tbl.push_back(mk(1, 1, NOP,  8'h00, 0,0,0, 8'h03, 0,0,0,0));
        tbl.push_back(mk(0, 1, JMP,  8'h55, 0,0,0, 8'h00, 0,0,0,0));
        tbl.push_back(mk(1, 1, JZ,   8'h40, 0,0,0, 8'h01, 0,0,0,0));
        tbl.push_back(mk(1, 1, JZ,   8'h40, 0,1,0, 8'h40, 1,0,0,0));
        tbl.push_back(mk(1, 1, JNC,  8'h60, 1,0,0, 8'h41, 0,0,0,0));
        tbl.push_back(mk(1, 1, JNC,  8'h60, 0,0,0, 8'h60, 1,0,0,0));
        tbl.push_back(mk(1, 1, JB,   8'h20, 0,0,1, 8'h20, 1,0,0,0));
        tbl.push_back(mk(1, 1, JNB,  8'h30, 0,0,1, 8'h21, 0,0,0,0));
        tbl.push_back(mk(1, 1, JNZ,  8'h10, 0,0,0, 8'h10, 1,0,0,0));
        tbl.push_back(mk(1, 1, CALL, 8'h80, 0,0,0, 8'h80, 1,0,0,0));
        tbl.push_back(mk(1, 1, RET,  8'h00, 0,0,0, 8'h11, 1,0,0,0));
        tbl.push_back(mk(1, 1, JC,   8'hFF, 1,0,0, 8'hFF, 1,0,0,0));
        tbl.push_back(mk(1, 1, NOP,  8'h00, 0,0,0, 8'h00, 0,0,0,0));
        tbl.push_back(mk(1, 1, JMP,  8'h22, 0,0,0, 8'h22, 1,0,0,0));
        tbl.push_back(mk(1, 0, JMP,  8'h33, 0,0,0, 8'h22, 1,0,0,0));
        tbl.push_back(mk(1, 0, NOP,  8'h00, 0,0,0, 8'h22, 1,0,0,0));
        tbl.push_back(mk(1, 1, 4'hA, 8'h44, 1,1,1, 8'h23, 0,0,0,0));
        tbl.push_back(mk(0, 1, NOP,  8'h00, 0,0,0, 8'h00, 0,0,0,0));
        tbl.push_back(mk(1, 1, RET,  8'h00, 0,0,0, 8'h01, 0,0,0,1));
        tbl.push_back(mk(1, 1, CALL, 8'h50, 0,0,0, 8'h50, 1,0,0,1));
        tbl.push_back(mk(1, 1, RET,  8'h00, 0,0,0, 8'h02, 1,0,0,1));
        tbl.push_back(mk(1, 1, JMP,  8'h05, 0,0,0, 8'h05, 1,0,0,1));
        tbl.push_back(mk(1, 1, HALT, 8'h00, 0,0,0, 8'h05, 0,1,0,1));
        tbl.push_back(mk(1, 1, JMP,  8'h77, 0,0,0, 8'h05, 0,1,0,1));
        tbl.push_back(mk(1, 0, JMP,  8'h77, 0,0,0, 8'h05, 0,1,0,1));
        tbl.push_back(mk(1, 1, CALL, 8'h66, 0,0,0, 8'h05, 0,1,0,1));
        tbl.push_back(mk(1, 1, RET,  8'h00, 0,0,0, 8'h05, 0,1,0,1));
        tbl.push_back(mk(1, 0, JMP,  8'h12, 0,0,0, 8'h05, 0,1,0,1));
        tbl.push_back(mk(0, 0, HALT, 8'h00, 0,0,0, 8'h00, 0,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].op, tbl[i].tgt, tbl[i].c, tbl[i].z, tbl[i].b);
            $display("vec %0d: rst=%0b en=%0b op=%0d tgt=%02h -> pc=%02h taken=%0b halted=%0b ovf=%0b unf=%0b",
                     i, tbl[i].rst, tbl[i].en, tbl[i].op, tbl[i].tgt, PC, TAKEN, HALTED, STK_OVF, STK_UNF);
            chk($sformatf("vec%0d.pc", i),     32'(PC),      32'(tbl[i].pc));
            chk($sformatf("vec%0d.taken", i),  32'(TAKEN),   32'(tbl[i].taken));
            chk($sformatf("vec%0d.halted", i), 32'(HALTED),  32'(tbl[i].halted));
            chk($sformatf("vec%0d.ovf", i),    32'(STK_OVF), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d.unf", i),    32'(STK_UNF), 32'(tbl[i].unf));
        end

        // Nested calls: four fill the stack, fifth overflows, returns unwind in reverse.
        mstep("nest.rst", 0, 1, NOP, 8'h00, 0, 0, 0);
        mstep("nest.jmp", 1, 1, JMP, 8'h10, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            mstep($sformatf("nest.call%0d", k), 1, 1, CALL, 8'(8'h80 + 8'(k * 16)), 0, 0, 0);
        chk("nest.ovf_direct", 32'(STK_OVF), 32'd1);
        chk("nest.pc_after_ovf", 32'(PC), 32'hB1);
        for (int k = 0; k < 4; k++)
            mstep($sformatf("nest.ret%0d", k), 1, 1, RET, 8'h00, 0, 0, 0);
        chk("nest.last_ret_pc", 32'(PC), 32'h11);
        mstep("nest.ret_empty", 1, 1, RET, 8'h00, 0, 0, 0);
        chk("nest.unf_direct", 32'(STK_UNF), 32'd1);

        // Return address pushed from 0xFF wraps to 0x00.
        mstep("wrap.rst", 0, 1, NOP, 8'h00, 0, 0, 0);
        mstep("wrap.jmp", 1, 1, JMP, 8'hFF, 0, 0, 0);
        mstep("wrap.call", 1, 1, CALL, 8'h40, 0, 0, 0);
        mstep("wrap.ret", 1, 1, RET, 8'h00, 0, 0, 0);
        chk("wrap.ret_pc", 32'(PC), 32'h00);

        // Reset during a stall.
        mstep("stall.jmp", 1, 1, JMP, 8'h9A, 0, 0, 0);
        mstep("stall.hold", 1, 0, JMP, 8'h11, 0, 0, 0);
        mstep("stall.rst", 0, 0, JMP, 8'h11, 0, 0, 0);

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            logic       r_rst;
            logic       r_en;
            logic [3:0] r_op;
            r_rst = ($urandom_range(0, 39) != 0);
            r_en  = ($urandom_range(0, 4) != 0);
            r_op  = 4'($urandom_range(0, 15));
            if (r_op == HALT && $urandom_range(0, 1) == 0) r_op = CALL;
            mstep($sformatf("rnd%0d", n), r_rst, r_en, r_op, 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_pc_branch.md
Name: cpu_pc_branch

Overview:
Program counter and branch-decision stage of the one-cycle CPU, directly downstream of the flag register.
- Consumes the registered C/Z/B flags together with the decoded branch opcode and target address.
- Selects the next instruction address each cycle.
- Maintains a small hardware return-address stack for CALL/RET and a RUN/HALTED state.
- Drives the instruction-memory address.

Parameters:
ADDR_W, 8, width of PC, TARGET and stack entries
STACK_DEPTH, 4, number of return-address entries (power of two, >= 2)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  reset; one clock; reset is synchronous and active-low
EN  input  1  advance enable; low = stall, all state held
OP  input  4  branch opcode from decoder (encodings in package)
TARGET  input  ADDR_W  absolute branch/call target
C  input  1  carry flag from flag register
Z  input  1  zero flag from flag register
B  input  1  borrow flag from flag register
PC  output  ADDR_W  current instruction address
TAKEN  output  1  last update loaded a non-sequential address
HALTED  output  1  core is in HALTED state
STK_OVF  output  1  sticky: CALL attempted with stack full
STK_UNF  output  1  sticky: RET attempted with stack empty

Behaviour:
- Reset (RST low at rising edge):
  - PC=0, TAKEN=0, HALTED=0, STK_OVF=0, STK_UNF=0.
  - Stack pointer=0 (empty); stack contents don't-care.
  - Reset overrides EN and OP, including mid-HALT and mid-stall.
- State machine: RUN, HALTED.
  - RUN -> HALTED on OP_HALT with EN=1.
  - HALTED -> RUN only via reset.
  - In HALTED: PC, stack and sticky flags are frozen; TAKEN=0; OP and EN are ignored.
- EN=0 in RUN: every register is held, including TAKEN (no change).
- Per enabled cycle in RUN, the next PC is determined by OP (flags sampled combinationally in the same cycle):
  - OP_NOP: PC+1.
  - OP_JMP: TARGET.
  - OP_JZ / OP_JNZ: TARGET if Z==1 / Z==0, else PC+1.
  - OP_JC / OP_JNC: TARGET if C==1 / C==0, else PC+1.
  - OP_JB / OP_JNB: TARGET if B==1 / B==0, else PC+1.
  - OP_CALL:
    - Stack not full: push PC+1, SP+1, PC=TARGET.
    - Stack full: no push, PC=PC+1, STK_OVF=1.
  - OP_RET:
    - Stack not empty: SP-1, PC=popped entry.
    - Stack empty: PC=PC+1, STK_UNF=1.
  - OP_HALT: PC held, enter HALTED.
  - Undefined codes: behave as OP_NOP.
- TAKEN:
  - Registered; set to 1 for a cycle whose update loaded TARGET or a popped address.
  - Otherwise 0, including for a failed CALL/RET and for HALT.
- Arithmetic:
  - PC+1 is modulo 2^ADDR_W: PC=max with OP_NOP yields 0.
  - The pushed value PC+1 wraps the same way.
- Stack:
  - LIFO; SP counts 0..STACK_DEPTH.
  - Full when SP==STACK_DEPTH; empty when SP==0.
  - A CALL at depth STACK_DEPTH-1 succeeds and makes the stack full.
- Sticky flags: cleared only by reset; they do not block later operations.
- Latency: the new PC is visible on the first rising edge after the OP is presented; there is no bubble.

Decomposition:
- Shared package cpu_pkg holds:
  - The OP encodings: NOP=0, JMP=1, JZ=2, JNZ=3, JC=4, JNC=5, JB=6, JNB=7, CALL=8, RET=9, HALT=15.
  - The RUN/HALTED state encoding.
  - Default ADDR_W.
- One natural sub-module: cpu_ret_stack, a parameterised LIFO with push/pop/full/empty.
  - Overflow/underflow policy stays in cpu_pc_branch.

Test Plan:
- Reset then 3 cycles OP_NOP, EN=1 -> PC 0,1,2,3; TAKEN=0; hold RST low mid-run at PC=3 -> PC=0 next edge.
- OP_JZ TARGET=0x40 with Z=0 -> PC=PC+1, TAKEN=0; repeat with Z=1 -> PC=0x40, TAKEN=1; same pair for JNC with C=1 (not taken) and JB with B=1 (taken).
- At PC=0x10 OP_CALL TARGET=0x80 -> PC=0x80; then OP_RET -> PC=0x11, TAKEN=1; nested 4 CALLs succeed, 5th -> PC+1, STK_OVF=1, and 4 RETs return in reverse order.
- OP_RET after reset -> PC=1, STK_UNF=1, TAKEN=0; STK_UNF stays 1 through later valid CALL/RET.
- PC=0xFF, OP_NOP -> PC=0x00; EN=0 with OP_JMP TARGET=0x22 -> PC and TAKEN unchanged.
- OP_HALT at PC=0x05 -> HALTED=1, PC stays 0x05 under OP_JMP/EN toggling for 5 cycles; RST low -> PC=0, HALTED=0.
